// File: rtl/or3_pattern_sequencer.sv
// Purpose: sweeps a/b/c through 000..111 for the 3-input OR gate, holding each pattern HOLD_CYCLES.
// Latency: first pattern one cycle after an accepted start; done pulse 8*HOLD_CYCLES+1 cycles after start.
// Backpressure: none; stop aborts to IDLE, start is ignored unless IDLE. OR3_SEQ_SELF_CHECK_EN adds y/err_cnt/err_flag.
module or3_pattern_sequencer #(
    parameter int HOLD_CYCLES = 100,
    parameter bit LOOP        = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
`ifdef OR3_SEQ_SELF_CHECK_EN
    input  logic       y,
    output logic [3:0] err_cnt,
    output logic       err_flag,
`endif
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] pat_idx,
    output logic       strobe,
    output logic       busy,
    output logic       done
);

    localparam int CW_RAW = $clog2(HOLD_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [2:0]    pat, pat_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          strobe_q, strobe_n;
    logic          last;
    logic          accept;

    assign last   = (cnt == LAST);
    assign accept = (state == S_IDLE) && start && !stop;

    // State, pattern, hold counter and strobe registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pat      <= 3'd0;
            cnt      <= '0;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_n;
            pat      <= pat_n;
            cnt      <= cnt_n;
            strobe_q <= strobe_n;
        end
    end

    // Next-state logic: pattern is cleared whenever the sweep leaves DRIVE so a/b/c read 000 outside it.
    always_comb begin
        state_n  = state;
        pat_n    = pat;
        cnt_n    = cnt;
        strobe_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n  = S_DRIVE;
                    pat_n    = 3'd0;
                    cnt_n    = '0;
                    strobe_n = 1'b1;
                end
            end
            S_DRIVE: begin
                if (stop) begin
                    state_n = S_IDLE;
                    pat_n   = 3'd0;
                    cnt_n   = '0;
                end else if (last) begin
                    cnt_n = '0;
                    if ((pat == 3'd7) && !LOOP) begin
                        state_n = S_DONE;
                        pat_n   = 3'd0;
                    end else begin
                        pat_n    = pat + 3'd1;
                        strobe_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE: begin
                // Single-cycle completion state; stop lands in IDLE just the same.
                state_n = S_IDLE;
                pat_n   = 3'd0;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                pat_n   = 3'd0;
                cnt_n   = '0;
            end
        endcase
    end

    assign a       = pat[2];
    assign b       = pat[1];
    assign c       = pat[0];
    assign pat_idx = pat;
    assign strobe  = strobe_q;
    assign busy    = (state == S_DRIVE);
    assign done    = (state == S_DONE);

`ifdef OR3_SEQ_SELF_CHECK_EN
    logic [3:0] err_q;

    // Compare the gate output on the last hold cycle of each pattern; saturating mismatch count.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 4'd0;
        end else if (accept) begin
            err_q <= 4'd0;
        end else if ((state == S_DRIVE) && last && (y != (a | b | c)) && (err_q != 4'hF)) begin
            err_q <= err_q + 4'd1;
        end
    end

    assign err_cnt  = err_q;
    assign err_flag = (err_q != 4'd0);
`endif

endmodule

// File: tb/tb_or3_pattern_sequencer.sv
// Directed bench for or3_pattern_sequencer: three instances (hold 4 single-shot, hold 1 single-shot, hold 2 looping).
// Inputs change and outputs are sampled on the falling edge.
// Expected values come from hand-derived per-cycle formulas for each sweep.
module tb_or3_pattern_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start4, stop4, start1, stop1, start2, stop2;
    logic a4, b4, c4, st4, bz4, dn4;
    logic a1, b1, c1, st1, bz1, dn1;
    logic a2, b2, c2, st2, bz2, dn2;
    logic [2:0] p4, p1, p2;

`ifdef OR3_SEQ_SELF_CHECK_EN
    logic y4, y1, y2;
    logic [3:0] err4, err1, err2;
    logic ef4, ef1, ef2;
    assign y4 = a4 | b4 | c4;
    assign y1 = 1'b0;
    assign y2 = 1'b0;
`endif

    or3_pattern_sequencer #(.HOLD_CYCLES(4), .LOOP(1'b0)) u4 (
        .clk(clk), .rst(rst), .start(start4), .stop(stop4),
`ifdef OR3_SEQ_SELF_CHECK_EN
        .y(y4), .err_cnt(err4), .err_flag(ef4),
`endif
        .a(a4), .b(b4), .c(c4), .pat_idx(p4), .strobe(st4), .busy(bz4), .done(dn4)
    );

    or3_pattern_sequencer #(.HOLD_CYCLES(1), .LOOP(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop1),
`ifdef OR3_SEQ_SELF_CHECK_EN
        .y(y1), .err_cnt(err1), .err_flag(ef1),
`endif
        .a(a1), .b(b1), .c(c1), .pat_idx(p1), .strobe(st1), .busy(bz1), .done(dn1)
    );

    or3_pattern_sequencer #(.HOLD_CYCLES(2), .LOOP(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2),
`ifdef OR3_SEQ_SELF_CHECK_EN
        .y(y2), .err_cnt(err2), .err_flag(ef2),
`endif
        .a(a2), .b(b2), .c(c2), .pat_idx(p2), .strobe(st2), .busy(bz2), .done(dn2)
    );

    logic [31:0] o4, o1, o2;
    assign o4 = {23'd0, a4, b4, c4, p4, st4, bz4, dn4};
    assign o1 = {23'd0, a1, b1, c1, p1, st1, bz1, dn1};
    assign o2 = {23'd0, a2, b2, c2, p2, st2, bz2, dn2};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected packed observation {a,b,c,pat_idx,strobe,busy,done}.
    function automatic logic [31:0] ev(input int p, input bit stb, input bit bsy, input bit dn);
        logic [2:0] q;
        q = p[2:0];
        return {23'd0, q, q, stb, bsy, dn};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        int wraps;
        logic [2:0] prev;
        bit bsy;

        rst = 1'b1;
        start4 = 1'b0; stop4 = 1'b0;
        start1 = 1'b0; stop1 = 1'b0;
        start2 = 1'b0; stop2 = 1'b0;
        cyc(); cyc();
        chk("reset_u4", o4, ev(0, 0, 0, 0));
        chk("reset_u1", o1, ev(0, 0, 0, 0));
        chk("reset_u2", o2, ev(0, 0, 0, 0));
        rst = 1'b0;
        cyc();

        // Full single sweep, hold 4; a second start at t=10 must not disturb it.
        start4 = 1'b1;
        for (int t = 1; t <= 34; t++) begin
            cyc();
            bsy = (t >= 1) && (t <= 32);
            chk($sformatf("sweep4_t%0d", t), o4,
                ev(bsy ? (t - 1) / 4 : 0, bsy && ((t - 1) % 4 == 0), bsy, t == 33));
            start4 = (t == 10);
        end
`ifdef OR3_SEQ_SELF_CHECK_EN
        chk("err_tied", 32'(err4), 32'd0);
        chk("errflag_tied", 32'(ef4), 32'd0);
`endif

        // Abort while pattern 3 is driven, then restart from 000.
        start4 = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            cyc();
            start4 = 1'b0;
            if (t >= 13) chk($sformatf("abort_pre_t%0d", t), o4, ev(3, t == 13, 1, 0));
        end
        stop4 = 1'b1;
        cyc();
        stop4 = 1'b0;
        chk("abort_idle", o4, ev(0, 0, 0, 0));
        for (int t = 0; t < 4; t++) begin
            cyc();
            chk($sformatf("abort_nodone_%0d", t), o4, ev(0, 0, 0, 0));
        end
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        chk("restart_first", o4, ev(0, 1, 1, 0));
        cyc();
        chk("restart_hold", o4, ev(0, 0, 1, 0));
        stop4 = 1'b1;
        cyc();
        stop4 = 1'b0;
        chk("restart_stop", o4, ev(0, 0, 0, 0));

        // Reset mid-sweep at pattern 5, then reset held together with start.
        start4 = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            cyc();
            start4 = 1'b0;
            if (t >= 21) chk($sformatf("pre_rst_t%0d", t), o4, ev(5, t == 21, 1, 0));
        end
        rst = 1'b1;
        cyc();
        chk("rst_mid", o4, ev(0, 0, 0, 0));
        start4 = 1'b1;
        cyc();
        chk("rst_with_start", o4, ev(0, 0, 0, 0));
        rst = 1'b0;
        start4 = 1'b0;
        cyc();
        chk("after_rst", o4, ev(0, 0, 0, 0));

        // Hold 1: new pattern every cycle, strobe high 8 cycles in a row.
        start1 = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            cyc();
            start1 = 1'b0;
            chk($sformatf("hold1_t%0d", t), o1, ev((t <= 8) ? t - 1 : 0, t <= 8, t <= 8, t == 9));
        end
`ifdef OR3_SEQ_SELF_CHECK_EN
        chk("err_stuck0", 32'(err1), 32'd7);
        chk("errflag_stuck0", 32'(ef1), 32'd1);
`endif

        // start and stop together in IDLE: stop wins.
        start1 = 1'b1;
        stop1  = 1'b1;
        cyc();
        chk("startstop_a", o1, ev(0, 0, 0, 0));
        cyc();
        chk("startstop_b", o1, ev(0, 0, 0, 0));
        start1 = 1'b0;
        stop1  = 1'b0;

        // Looping, hold 2: wraps 111 -> 000 with strobe and never pulses done.
        start2 = 1'b1;
        wraps = 0;
        prev = 3'd0;
        for (int t = 1; t <= 50; t++) begin
            cyc();
            start2 = 1'b0;
            chk($sformatf("loop_t%0d", t), o2, ev(((t - 1) / 2) % 8, (t - 1) % 2 == 0, 1, 0));
            if ((prev == 3'd7) && (p2 == 3'd0)) wraps++;
            prev = p2;
            if (t == 40) chk("loop_wraps", 32'(wraps), 32'd2);
        end
        stop2 = 1'b1;
        cyc();
        stop2 = 1'b0;
        chk("loop_stop", o2, ev(0, 0, 0, 0));
`ifdef OR3_SEQ_SELF_CHECK_EN
        chk("err_saturate", 32'(err2), 32'd15);
        chk("errflag_saturate", 32'(ef2), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
